// File: rtl/frontend_flush_ctrl_pkg.sv
// rtl/frontend_flush_ctrl_pkg.sv - shared encodings and reset PC for the frontend flush controller
package frontend_flush_ctrl_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h1C00_0000;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_DRAIN     = 2'b01,
    ST_IDLE_WAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_BR      = 2'b00,
    CAUSE_EXCP    = 2'b01,
    CAUSE_ERTN    = 2'b10,
    CAUSE_REFETCH = 2'b11
  } cause_e;

  // Bit positions of the event vector, highest priority at the top
  localparam int EV_EXCP    = 4;
  localparam int EV_ERTN    = 3;
  localparam int EV_REFETCH = 2;
  localparam int EV_IDLE    = 1;
  localparam int EV_BR      = 0;

endpackage

// File: rtl/frontend_flush_ctrl_prio_enc.sv
// rtl/frontend_flush_ctrl_prio_enc.sv - fixed-priority encode of flush events to one-hot grant plus cause
module frontend_flush_ctrl_prio_enc
  import frontend_flush_ctrl_pkg::*;
(
  input  logic [4:0] events,
  output logic [4:0] grant,
  output cause_e     cause,
  output logic       any_event
);

  always_comb begin
    grant = '0;
    cause = CAUSE_BR;
    if (events[EV_EXCP]) begin
      grant[EV_EXCP] = 1'b1;
      cause          = CAUSE_EXCP;
    end else if (events[EV_ERTN]) begin
      grant[EV_ERTN] = 1'b1;
      cause          = CAUSE_ERTN;
    end else if (events[EV_REFETCH]) begin
      grant[EV_REFETCH] = 1'b1;
      cause             = CAUSE_REFETCH;
    end else if (events[EV_IDLE]) begin
      grant[EV_IDLE] = 1'b1;
      cause          = CAUSE_REFETCH;
    end else if (events[EV_BR]) begin
      grant[EV_BR] = 1'b1;
      cause        = CAUSE_BR;
    end
  end

  assign any_event = |events;

endmodule

// File: rtl/frontend_flush_ctrl.sv
// rtl/frontend_flush_ctrl.sv - commit/branch flush arbitration, redirect generation and IBAR/IDLE hold FSM
module frontend_flush_ctrl
  import frontend_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             excp_valid,
  input  logic [31:0]      excp_target,
  input  logic             ertn_valid,
  input  logic [31:0]      ertn_target,
  input  logic             refetch_valid,
  input  logic [31:0]      refetch_pc,
  input  logic             refetch_ibar,
  input  logic             idle_valid,
  input  logic [31:0]      idle_pc,
  input  logic             br_valid,
  input  logic [31:0]      br_target,
  input  logic             icache_busy,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             fifo_id_flush,
  output logic [1:0]       fifo_id_flush_cause,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             frontend_stall,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] flush_count
);

  state_e      st, st_nxt;
  logic [4:0]  events, grant;
  cause_e      enc_cause;
  logic        any_event, flush_full, drain_hold;
  logic        redirect_valid_nxt;
  logic [31:0] redirect_pc_nxt, latched_pc, latched_pc_nxt;

  assign drain_hold = refetch_ibar & icache_busy;

  // Outside RUN only an exception may interrupt; a branch loses to any higher-class flush in flight
  always_comb begin
    events          = '0;
    events[EV_EXCP] = excp_valid;
    if (st == ST_RUN) begin
      events[EV_ERTN]    = ertn_valid;
      events[EV_REFETCH] = refetch_valid;
      events[EV_IDLE]    = idle_valid;
      events[EV_BR]      = br_valid & ~flush_ex;
    end
  end

  frontend_flush_ctrl_prio_enc u_prio_enc (
    .events    (events),
    .grant     (grant),
    .cause     (enc_cause),
    .any_event (any_event)
  );

  assign flush_full = |grant[EV_EXCP:EV_IDLE];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= ST_RUN;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_RUN: begin
        if (grant[EV_REFETCH] && drain_hold) st_nxt = ST_DRAIN;
        else if (grant[EV_IDLE])             st_nxt = ST_IDLE_WAIT;
      end
      ST_DRAIN:     if (grant[EV_EXCP] || !icache_busy) st_nxt = ST_RUN;
      ST_IDLE_WAIT: if (grant[EV_EXCP])                 st_nxt = ST_RUN;
      default:      st_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    redirect_valid_nxt = 1'b0;
    redirect_pc_nxt    = redirect_pc;
    latched_pc_nxt     = latched_pc;
    if (grant[EV_EXCP]) begin
      redirect_valid_nxt = 1'b1;
      redirect_pc_nxt    = excp_target;
    end else if (grant[EV_ERTN]) begin
      redirect_valid_nxt = 1'b1;
      redirect_pc_nxt    = ertn_target;
    end else if (grant[EV_REFETCH]) begin
      if (drain_hold) begin
        latched_pc_nxt = refetch_pc;
      end else begin
        redirect_valid_nxt = 1'b1;
        redirect_pc_nxt    = refetch_pc;
      end
    end else if (grant[EV_IDLE]) begin
      latched_pc_nxt = idle_pc;
    end else if (grant[EV_BR]) begin
      redirect_valid_nxt = 1'b1;
      redirect_pc_nxt    = br_target;
    end else if (st == ST_DRAIN && !icache_busy) begin
      redirect_valid_nxt = 1'b1;
      redirect_pc_nxt    = latched_pc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_valid      <= 1'b0;
      redirect_pc         <= PC_RESET;
      latched_pc          <= PC_RESET;
      flush_if            <= 1'b0;
      fifo_id_flush       <= 1'b0;
      fifo_id_flush_cause <= CAUSE_BR;
      flush_id            <= 1'b0;
      flush_ex            <= 1'b0;
      flush_count         <= '0;
    end else begin
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      latched_pc     <= latched_pc_nxt;
      flush_if       <= any_event;
      fifo_id_flush  <= any_event;
      flush_id       <= any_event;
      flush_ex       <= flush_full;
      if (any_event) begin
        fifo_id_flush_cause <= enc_cause;
        flush_count         <= flush_count + CNT_W'(1);
      end
    end
  end

  assign frontend_stall = (st != ST_RUN);
  assign state          = st;

endmodule

// File: tb/tb_frontend_flush_ctrl.sv
// tb/tb_frontend_flush_ctrl.sv - directed and random checks of frontend_flush_ctrl against a cycle model
module tb_frontend_flush_ctrl;

  localparam logic [31:0] PC_RST = 32'h1C00_0000;
  localparam int          CW     = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          excp_valid, ertn_valid, refetch_valid, refetch_ibar, idle_valid, br_valid, icache_busy;
  logic [31:0]   excp_target, ertn_target, refetch_pc, idle_pc, br_target;
  logic          redirect_valid, flush_if, fifo_id_flush, flush_id, flush_ex, frontend_stall;
  logic [31:0]   redirect_pc;
  logic [1:0]    fifo_id_flush_cause, state;
  logic [CW-1:0] flush_count;

  always #5 clk = ~clk;

  frontend_flush_ctrl #(.PC_RESET(PC_RST), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn),
    .excp_valid(excp_valid), .excp_target(excp_target),
    .ertn_valid(ertn_valid), .ertn_target(ertn_target),
    .refetch_valid(refetch_valid), .refetch_pc(refetch_pc), .refetch_ibar(refetch_ibar),
    .idle_valid(idle_valid), .idle_pc(idle_pc),
    .br_valid(br_valid), .br_target(br_target),
    .icache_busy(icache_busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .fifo_id_flush(fifo_id_flush), .fifo_id_flush_cause(fifo_id_flush_cause),
    .flush_id(flush_id), .flush_ex(flush_ex), .frontend_stall(frontend_stall),
    .state(state), .flush_count(flush_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 run, 1 waiting for icache, 2 idle; event class 5 excp .. 1 branch, 0 none
  int          mode, m_cnt;
  logic [31:0] m_lat, e_pc;
  logic [1:0]  e_cause;
  bit          e_rv, e_fif, e_ffl, e_fid, e_fex;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, e_rv});
    chk({pfx, ".redirect_pc"}, redirect_pc, e_pc);
    chk({pfx, ".flush_if"}, {31'b0, flush_if}, {31'b0, e_fif});
    chk({pfx, ".fifo_id_flush"}, {31'b0, fifo_id_flush}, {31'b0, e_ffl});
    chk({pfx, ".cause"}, {30'b0, fifo_id_flush_cause}, {30'b0, e_cause});
    chk({pfx, ".flush_id"}, {31'b0, flush_id}, {31'b0, e_fid});
    chk({pfx, ".flush_ex"}, {31'b0, flush_ex}, {31'b0, e_fex});
    chk({pfx, ".stall"}, {31'b0, frontend_stall}, {31'b0, mode != 0});
    chk({pfx, ".state"}, {30'b0, state}, mode);
    chk({pfx, ".flush_count"}, {{(32-CW){1'b0}}, flush_count}, m_cnt);
  endtask

  task automatic model_reset();
    mode = 0; m_cnt = 0; m_lat = PC_RST; e_pc = PC_RST; e_cause = 2'b00;
    e_rv = 0; e_fif = 0; e_ffl = 0; e_fid = 0; e_fex = 0;
  endtask

  task automatic clear_events();
    excp_valid = 0; ertn_valid = 0; refetch_valid = 0; refetch_ibar = 0; idle_valid = 0; br_valid = 0;
  endtask

  task automatic cycle(input string pfx);
    int cls;
    cls = 0;
    if (mode == 0) begin
      if (excp_valid)              cls = 5;
      else if (ertn_valid)         cls = 4;
      else if (refetch_valid)      cls = 3;
      else if (idle_valid)         cls = 2;
      else if (br_valid && !e_fex) cls = 1;
    end else if (excp_valid) begin
      cls = 5;
    end
    e_rv = 0; e_fif = 0; e_ffl = 0; e_fid = 0; e_fex = 0;
    if (cls != 0) begin
      e_fif = 1; e_ffl = 1; e_fid = 1; e_fex = (cls != 1);
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    case (cls)
      5: begin e_rv = 1; e_pc = excp_target; e_cause = 2'b01; mode = 0; end
      4: begin e_rv = 1; e_pc = ertn_target; e_cause = 2'b10; end
      3: begin
        e_cause = 2'b11;
        if (refetch_ibar && icache_busy) begin mode = 1; m_lat = refetch_pc; end
        else begin e_rv = 1; e_pc = refetch_pc; end
      end
      2: begin e_cause = 2'b11; mode = 2; m_lat = idle_pc; end
      1: begin e_rv = 1; e_pc = br_target; e_cause = 2'b00; end
      default: if (mode == 1 && !icache_busy) begin e_rv = 1; e_pc = m_lat; mode = 0; end
    endcase
    @(posedge clk);
    #1;
    check_all(pfx);
    @(negedge clk);
    clear_events();
  endtask

  initial begin
    rstn = 0; icache_busy = 0;
    clear_events();
    excp_target = 0; ertn_target = 0; refetch_pc = 0; idle_pc = 0; br_target = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    rstn = 1;

    repeat (4) cycle("quiet");
    br_valid = 1; br_target = 32'h1C00_0100;
    cycle("branch");

    excp_valid = 1; excp_target = 32'h1C00_8000; br_valid = 1; br_target = 32'h1C00_0300;
    cycle("excp_vs_br");
    br_valid = 1; br_target = 32'h1C00_0304;
    cycle("br_after_excp");
    ertn_valid = 1; ertn_target = 32'h1C00_0500; refetch_valid = 1; refetch_pc = 32'h1C00_0600;
    cycle("ertn_vs_refetch");

    icache_busy = 1;
    refetch_valid = 1; refetch_ibar = 1; refetch_pc = 32'h1C00_0040;
    cycle("ibar_enter");
    br_valid = 1; ertn_valid = 1; ertn_target = 32'h1C00_0700;
    cycle("drain_ignore");
    cycle("drain_hold");
    icache_busy = 0;
    cycle("drain_release");
    cycle("after_drain");

    idle_valid = 1; idle_pc = 32'h1C00_0200;
    cycle("idle_enter");
    cycle("idle_w1");
    cycle("idle_w2");
    br_valid = 1; br_target = 32'h1C00_0900; refetch_valid = 1; refetch_pc = 32'h1C00_0A00;
    cycle("idle_br");
    excp_valid = 1; excp_target = 32'h1C00_8000;
    cycle("idle_excp");

    icache_busy = 1;
    refetch_valid = 1; refetch_ibar = 1; refetch_pc = 32'h1C00_0080;
    cycle("drain2_enter");
    excp_valid = 1; excp_target = 32'h1C00_8010;
    cycle("drain_excp");
    cycle("drain_excp_after");

    refetch_valid = 1; refetch_ibar = 1; refetch_pc = 32'h1C00_00C0;
    cycle("drain3_enter");
    #2 rstn = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rstn = 1; icache_busy = 0;
    cycle("post_reset1");
    cycle("post_reset2");

    for (int i = 0; i < 17; i++) begin
      br_valid = 1; br_target = 32'h1C00_1000 + 32'(i * 4);
      cycle("wrap");
    end

    for (int i = 0; i < 600; i++) begin
      excp_valid    = ($urandom_range(0, 99) < 5);
      ertn_valid    = ($urandom_range(0, 99) < 5);
      refetch_valid = ($urandom_range(0, 99) < 10);
      refetch_ibar  = $urandom_range(0, 1);
      idle_valid    = ($urandom_range(0, 99) < 5);
      br_valid      = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 20) icache_busy = ~icache_busy;
      excp_target = $urandom; ertn_target = $urandom; refetch_pc = $urandom;
      idle_pc = $urandom; br_target = $urandom;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
